// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - data-RAM request/grant/response bus between the lsu and memory
interface lsu_if #(
  parameter int XLEN = 32
);
  logic            bus_req_o;
  logic            bus_we_o;
  logic [XLEN-1:0] bus_addr_o;
  logic [3:0]      bus_be_o;
  logic [XLEN-1:0] bus_wdata_o;
  logic            bus_gnt_i;
  logic            bus_rvalid_i;
  logic [XLEN-1:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_gnt_i, bus_rvalid_i, bus_rdata_i
  );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - hxd32 load/store unit driving the data-RAM request/grant/response bus
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [2:0]      dram_rd_sel_i,
  input  logic [1:0]      dram_wr_sel_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  output logic            stall_o,
  output logic            misalign_o,
  output logic [2:0]      dram_rd_sel_o,
  output logic [XLEN-1:0] dram_rd_data_o,
  output logic            done_o,
  output logic            bus_err_o,
  lsu_if.master           bus
);

  localparam logic [2:0] DRAM_RD_B  = 3'd1;
  localparam logic [2:0] DRAM_RD_H  = 3'd2;
  localparam logic [2:0] DRAM_RD_W  = 3'd3;
  localparam logic [2:0] DRAM_RD_BU = 3'd4;
  localparam logic [2:0] DRAM_RD_HU = 3'd5;
  localparam logic [1:0] DRAM_WR_B  = 2'd1;
  localparam logic [1:0] DRAM_WR_H  = 2'd2;
  localparam logic [1:0] DRAM_WR_W  = 2'd3;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  state_e          state_q, state_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [XLEN-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]      bus_be_q, bus_be_d;
  logic [XLEN-1:0] bus_wdata_q, bus_wdata_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      rd_sel_q, rd_sel_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic            is_load, is_store, req_valid, misaligned, timeout;
  logic [1:0]      size;
  logic [3:0]      be_dec;
  logic [XLEN-1:0] wdata_dec, rdata_aligned;

  // size: 0 = byte, 1 = half, 2 = word; a valid load masks any store
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = 2'd0;
    case (dram_rd_sel_i)
      DRAM_RD_B, DRAM_RD_BU: begin is_load = 1'b1; size = 2'd0; end
      DRAM_RD_H, DRAM_RD_HU: begin is_load = 1'b1; size = 2'd1; end
      DRAM_RD_W:             begin is_load = 1'b1; size = 2'd2; end
      default:               is_load = 1'b0;
    endcase
    if (!is_load) begin
      case (dram_wr_sel_i)
        DRAM_WR_B: begin is_store = 1'b1; size = 2'd0; end
        DRAM_WR_H: begin is_store = 1'b1; size = 2'd1; end
        DRAM_WR_W: begin is_store = 1'b1; size = 2'd2; end
        default:   is_store = 1'b0;
      endcase
    end
    req_valid  = is_load | is_store;
    misaligned = ((size == 2'd1) && addr_i[0]) || ((size == 2'd2) && (addr_i[1:0] != 2'd0));
    case (size)
      2'd0:    begin be_dec = 4'b0001 << addr_i[1:0]; wdata_dec = {4{wr_data_i[7:0]}};  end
      2'd1:    begin be_dec = 4'b0011 << addr_i[1:0]; wdata_dec = {2{wr_data_i[15:0]}}; end
      default: begin be_dec = 4'hF;                   wdata_dec = wr_data_i;             end
    endcase
  end

  assign rdata_aligned = bus.bus_rdata_i >> {off_q, 3'b000};

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Restarts on every entry into REQ or WAIT so each phase gets the full budget
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && ((state_q == REQ) || (state_q == WAIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    off_d       = off_q;
    rd_sel_d    = rd_sel_q;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && !misaligned) begin
          state_d     = REQ;
          bus_req_d   = 1'b1;
          bus_we_d    = !is_load;
          bus_addr_d  = {addr_i[XLEN-1:2], 2'b00};
          bus_be_d    = be_dec;
          bus_wdata_d = wdata_dec;
          off_d       = addr_i[1:0];
          if (is_load) rd_sel_d = dram_rd_sel_i;
        end
      end
      REQ: begin
        if (bus.bus_gnt_i) begin
          bus_req_d = 1'b0;
          if (bus_we_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else if (bus.bus_rvalid_i) begin
            rd_data_d = rdata_aligned;
            state_d   = DONE;
            done_d    = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else if (timeout) begin
          bus_req_d = 1'b0;
          state_d   = DONE;
          done_d    = 1'b1;
          err_d     = 1'b1;
          if (!bus_we_q) rd_data_d = '0;
        end
      end
      WAIT: begin
        if (bus.bus_rvalid_i) begin
          rd_data_d = rdata_aligned;
          state_d   = DONE;
          done_d    = 1'b1;
        end else if (timeout) begin
          rd_data_d = '0;
          state_d   = DONE;
          done_d    = 1'b1;
          err_d     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      off_q       <= '0;
      rd_sel_q    <= '0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      off_q       <= off_d;
      rd_sel_q    <= rd_sel_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign misalign_o      = (state_q == IDLE) && req_valid && misaligned;
  assign stall_o         = ((state_q == IDLE) && req_valid && !misaligned) ||
                           (state_q == REQ) || (state_q == WAIT);
  assign done_o          = done_q;
  assign bus_err_o       = err_q;
  assign dram_rd_sel_o   = rd_sel_q;
  assign dram_rd_data_o  = rd_data_q;
  assign bus.bus_req_o   = bus_req_q;
  assign bus.bus_we_o    = bus_we_q;
  assign bus.bus_addr_o  = bus_addr_q;
  assign bus.bus_be_o    = bus_be_q;
  assign bus.bus_wdata_o = bus_wdata_q;

endmodule
